// File: rtl/serial_deframer.sv
// serial_deframer: MSB-first serial-to-parallel receive stage with sync-marker
// word alignment, a one-word valid/ready holding register, and sticky overflow
// and framing-error flags.
// Optional feature: define DESER_PARITY_EN to append one even-parity bit to
// every word and report the check result on ParityErr.
module serial_deframer #(
    parameter int NBits = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             In,
    input  logic             InValid,
    input  logic             Sync,
    output logic [NBits-1:0] Data,
    output logic             DataValid,
    input  logic             DataReady,
    output logic             Overflow,
    output logic             FrameErr,
    output logic             ParityErr
);

    localparam int CW = $clog2(NBits + 2);
`ifdef DESER_PARITY_EN
    localparam int WordLen = NBits + 1;
`else
    localparam int WordLen = NBits;
`endif
    // count holds the number of bits already received, so this is its value
    // when the final bit of a word is on In
    localparam logic [CW-1:0] LastIdx = CW'(WordLen - 1);

    typedef enum logic {
        HUNT,
        SHIFT
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count, count_next;
    logic [NBits-1:0] sr, sr_next;
    logic [NBits-1:0] word;
    logic             word_done;
    logic             frame_err_next;
    logic             load_word;
`ifdef DESER_PARITY_EN
    logic             parity_bad;
`endif

    // Next-state logic: hunt for a sync marker, then count bits into words
    always_comb begin
        state_next     = state;
        count_next     = count;
        sr_next        = sr;
        word           = sr;
        word_done      = 1'b0;
        frame_err_next = 1'b0;
`ifdef DESER_PARITY_EN
        parity_bad     = 1'b0;
`endif
        case (state)
            HUNT: begin
                if (InValid && Sync) begin
                    state_next = SHIFT;
                    sr_next    = {{(NBits-1){1'b0}}, In};
                    count_next = CW'(1);
                end
            end
            SHIFT: begin
                if (InValid) begin
                    if (Sync && (count != '0)) begin
                        frame_err_next = 1'b1;
                        sr_next        = {{(NBits-1){1'b0}}, In};
                        count_next     = CW'(1);
                    end else if (count == LastIdx) begin
                        word_done  = 1'b1;
                        count_next = '0;
`ifdef DESER_PARITY_EN
                        word       = sr;
                        parity_bad = (^sr) ^ In;
`else
                        word       = {sr[NBits-2:0], In};
                        sr_next    = word;
`endif
                    end else begin
                        sr_next    = {sr[NBits-2:0], In};
                        count_next = count + CW'(1);
                    end
                end
            end
            default: state_next = HUNT;
        endcase
    end

    // A completed word may load when the holding register is empty or draining
    assign load_word = word_done && (!DataValid || DataReady);

    // Framing state register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= HUNT;
            count    <= '0;
            sr       <= '0;
            FrameErr <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            sr       <= sr_next;
            FrameErr <= frame_err_next;
        end
    end

    // Holding register with handshake and sticky overflow on a dropped word
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Data      <= '0;
            DataValid <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            if (load_word) begin
                Data      <= word;
                DataValid <= 1'b1;
            end else if (DataValid && DataReady) begin
                DataValid <= 1'b0;
            end
            if (word_done && !load_word) begin
                Overflow <= 1'b1;
            end
        end
    end

`ifdef DESER_PARITY_EN
    // Parity result travels with the word it belongs to
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ParityErr <= 1'b0;
        end else if (load_word) begin
            ParityErr <= parity_bad;
        end
    end
`else
    assign ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deframer.sv
// tb_serial_deframer: directed self-checking bench for serial_deframer.
// Works in both builds; parity-specific checks only run with DESER_PARITY_EN.
module tb_serial_deframer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       In = 1'b0;
    logic       InValid = 1'b0;
    logic       Sync = 1'b0;
    logic [7:0] Data;
    logic       DataValid;
    logic       DataReady = 1'b1;
    logic       Overflow;
    logic       FrameErr;
    logic       ParityErr;

`ifdef DESER_PARITY_EN
    localparam int WordLen = 9;
`else
    localparam int WordLen = 8;
`endif

    typedef struct {
        logic [7:0] data;
        logic       parity;
        int         cycle;
    } rec_t;

    rec_t recQ[$];
    int   cycle = 0;
    int   frameErrSeen = 0;
    int   testsRun = 0;
    int   testsFailed = 0;

    serial_deframer #(.NBits(8)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .In        (In),
        .InValid   (InValid),
        .Sync      (Sync),
        .Data      (Data),
        .DataValid (DataValid),
        .DataReady (DataReady),
        .Overflow  (Overflow),
        .FrameErr  (FrameErr),
        .ParityErr (ParityErr)
    );

    always #5 Clock = ~Clock;

    // Cycle counter used to measure spacing between delivered words
    always @(posedge Clock) cycle <= cycle + 1;

    // Record every accepted word and every FrameErr pulse, mid-cycle
    always @(negedge Clock) begin
        if (DataValid && DataReady) recQ.push_back('{Data, ParityErr, cycle});
        if (FrameErr) frameErrSeen++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkWord(input string tag, input int idx, input logic [7:0] expData);
        logic [7:0] got;
        got = (recQ.size() > idx) ? recQ[idx].data : 8'hxx;
        checkOutput(tag, {24'b0, got}, {24'b0, expData});
    endtask

    task automatic applyReset();
        @(posedge Clock); #1;
        Reset = 1'b1; InValid = 1'b0; Sync = 1'b0; In = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b0;
    endtask

    task automatic sendBit(input logic b, input logic s);
        @(posedge Clock); #1;
        In = b; Sync = s; InValid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clock); #1;
            In = 1'b0; Sync = 1'b0; InValid = 1'b0;
        end
    endtask

    // Sends one word MSB-first, with the even-parity bit when parity is built in
    task automatic sendWord(input logic [7:0] w, input logic syncFirst);
        for (int i = 7; i >= 0; i--) sendBit(w[i], (i == 7) ? syncFirst : 1'b0);
`ifdef DESER_PARITY_EN
        sendBit(^w, 1'b0);
`endif
    endtask

    initial begin
        logic [7:0] w;

        // Reset state
        applyReset();
        checkOutput("rst_data", {24'b0, Data}, 32'h0);
        checkOutput("rst_valid", {31'b0, DataValid}, 32'h0);
        checkOutput("rst_overflow", {31'b0, Overflow}, 32'h0);
        checkOutput("rst_frameerr", {31'b0, FrameErr}, 32'h0);
        checkOutput("rst_parityerr", {31'b0, ParityErr}, 32'h0);

        // Single synced word with consumer always ready
        recQ.delete();
        sendWord(8'hA5, 1'b1);
        @(posedge Clock); #1;
        checkOutput("a5_valid_next", {31'b0, DataValid}, 32'h1);
        checkOutput("a5_data_next", {24'b0, Data}, 32'hA5);
        In = 1'b0; Sync = 1'b0; InValid = 1'b0;
        idle(2);
        checkOutput("a5_count", recQ.size(), 1);
        checkWord("a5_data", 0, 8'hA5);
        checkOutput("a5_valid_drop", {31'b0, DataValid}, 32'h0);
        checkOutput("a5_parity", {31'b0, (recQ.size() > 0) ? recQ[0].parity : 1'bx}, 32'h0);

        // Back-to-back words, sync only on the very first bit
        recQ.delete();
        sendWord(8'h3C, 1'b1);
        sendWord(8'hC3, 1'b0);
        idle(3);
        checkOutput("b2b_count", recQ.size(), 2);
        checkWord("b2b_first", 0, 8'h3C);
        checkWord("b2b_second", 1, 8'hC3);
        checkOutput("b2b_gap", (recQ.size() > 1) ? recQ[1].cycle - recQ[0].cycle : -1, WordLen);
        checkOutput("b2b_overflow", {31'b0, Overflow}, 32'h0);
        checkOutput("b2b_frameerr", frameErrSeen, 0);

        // Idle cycles between bits do not advance the bit count
        recQ.delete();
        w = 8'h81;
        for (int i = 7; i >= 0; i--) begin
            sendBit(w[i], i == 7);
            idle(2);
        end
`ifdef DESER_PARITY_EN
        sendBit(^w, 1'b0);
`endif
        idle(3);
        checkOutput("gap_count", recQ.size(), 1);
        checkWord("gap_data", 0, 8'h81);

        // Consumer stalled: second word is dropped and overflow sticks
        recQ.delete();
        DataReady = 1'b0;
        sendWord(8'h11, 1'b0);
        sendWord(8'h22, 1'b0);
        idle(2);
        checkOutput("ovf_valid", {31'b0, DataValid}, 32'h1);
        checkOutput("ovf_data", {24'b0, Data}, 32'h11);
        checkOutput("ovf_flag", {31'b0, Overflow}, 32'h1);
        checkOutput("ovf_none_taken", recQ.size(), 0);
        DataReady = 1'b1;
        @(posedge Clock); #1;
        checkOutput("ovf_drain_valid", {31'b0, DataValid}, 32'h0);
        checkOutput("ovf_drain_count", recQ.size(), 1);
        checkWord("ovf_drain_data", 0, 8'h11);
        checkOutput("ovf_sticky", {31'b0, Overflow}, 32'h1);

        // Mid-word sync on the 4th bit restarts the word and pulses FrameErr
        applyReset();
        checkOutput("ovf_cleared", {31'b0, Overflow}, 32'h0);
        recQ.delete();
        frameErrSeen = 0;
        sendBit(1'b1, 1'b1);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        sendWord(8'h5A, 1'b1);
        idle(3);
        checkOutput("ferr_pulses", frameErrSeen, 1);
        checkOutput("ferr_count", recQ.size(), 1);
        checkWord("ferr_data", 0, 8'h5A);

        // Reset mid-word, stray Sync without InValid, unsynced bits ignored
        recQ.delete();
        sendBit(1'b1, 1'b1);
        sendBit(1'b1, 1'b0);
        sendBit(1'b0, 1'b0);
        applyReset();
        checkOutput("mid_rst_data", {24'b0, Data}, 32'h0);
        checkOutput("mid_rst_valid", {31'b0, DataValid}, 32'h0);
        @(posedge Clock); #1;
        Sync = 1'b1; In = 1'b1; InValid = 1'b0;
        sendWord(8'hFF, 1'b0);
        idle(3);
        checkOutput("hunt_discard", recQ.size(), 0);
        sendWord(8'hF0, 1'b1);
        idle(1);
        checkOutput("f0_data_reg", {24'b0, Data}, 32'hF0);
        idle(2);
        checkOutput("f0_count", recQ.size(), 1);
        checkWord("f0_data", 0, 8'hF0);
        checkOutput("f0_overflow", {31'b0, Overflow}, 32'h0);
        checkOutput("f0_parityerr", {31'b0, ParityErr}, 32'h0);
        checkOutput("f0_frameerr", frameErrSeen, 1);

        // Sync on a word boundary while already aligned is legal
        recQ.delete();
        sendWord(8'h96, 1'b1);
        idle(3);
        checkOutput("resync_frameerr", frameErrSeen, 1);
        checkWord("resync_data", 0, 8'h96);

`ifdef DESER_PARITY_EN
        // Parity good and bad; the word is delivered either way
        recQ.delete();
        w = 8'h07;
        for (int i = 7; i >= 0; i--) sendBit(w[i], 1'b0);
        sendBit(1'b1, 1'b0);
        for (int i = 7; i >= 0; i--) sendBit(w[i], 1'b0);
        sendBit(1'b0, 1'b0);
        idle(3);
        checkOutput("par_count", recQ.size(), 2);
        checkWord("par_good_data", 0, 8'h07);
        checkOutput("par_good_err", {31'b0, (recQ.size() > 0) ? recQ[0].parity : 1'bx}, 32'h0);
        checkWord("par_bad_data", 1, 8'h07);
        checkOutput("par_bad_err", {31'b0, (recQ.size() > 1) ? recQ[1].parity : 1'bx}, 32'h1);

        // Sync landing on the parity position is a framing error
        recQ.delete();
        for (int i = 7; i >= 0; i--) sendBit(w[i], 1'b0);
        sendBit(1'b1, 1'b1);
        idle(3);
        checkOutput("par_sync_ferr", frameErrSeen, 2);
        checkOutput("par_sync_nodata", recQ.size(), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
